// File: rtl/shift_add_mul8_pkg.sv
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared types and widths for the shift-and-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  localparam logic [2:0] ITER_LAST = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_add_mul8_if.sv
// ============================================================================
// Module   : shift_add_mul8_if
// Purpose  : Start/done handshake and operand/product bus of the multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_add_mul8_if;
  import mul_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );

endinterface

`default_nettype wire

// File: rtl/shift_add_mul8_csa16.sv
// ============================================================================
// Module   : CSA_16b
// Purpose  : 16-bit carry-select adder, four 4-bit blocks with dual sums.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module CSA_16b (
  input  wire logic [15:0] A,
  input  wire logic [15:0] B,
  input  wire logic        Cin,
  output logic      [15:0] S,
  output logic             Cout
);

  logic [4:0] w_c;

  assign w_c[0] = Cin;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_blk
      logic [4:0] w_s0;
      logic [4:0] w_s1;

      // Both carry-in outcomes are precomputed; the incoming carry only selects.
      assign w_s0 = {1'b0, A[4*g +: 4]} + {1'b0, B[4*g +: 4]};
      assign w_s1 = {1'b0, A[4*g +: 4]} + {1'b0, B[4*g +: 4]} + 5'd1;

      assign S[4*g +: 4] = w_c[g] ? w_s1[3:0] : w_s0[3:0];
      assign w_c[g+1]    = w_c[g] ? w_s1[4]   : w_s0[4];
    end
  endgenerate

  assign Cout = w_c[4];

endmodule

`default_nettype wire

// File: rtl/shift_add_mul8.sv
// ============================================================================
// Module   : shift_add_mul8
// Purpose  : Sequential 8x8 unsigned shift-and-add multiplier, start/done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_mul8
  import mul_pkg::*;
#(
  parameter int EARLY_EXIT = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  shift_add_mul8_if.slave   mif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PROD_W-1:0] r_mcand;
  logic [OP_W-1:0]   r_mplr;
  logic [PROD_W-1:0] r_acc;
  logic [2:0]        r_cnt;
  logic [PROD_W-1:0] r_p;

  logic              w_accept;
  logic              w_finish;
  logic [PROD_W-1:0] w_sum;
  logic [PROD_W-1:0] w_acc_nxt;
  logic              w_cout;
  logic              w_mplr_empty;

  CSA_16b u_csa (
    .A    (r_acc),
    .B    (r_mcand),
    .Cin  (1'b0),
    .S    (w_sum),
    .Cout (w_cout)
  );

  // Remaining multiplier bits after this iteration's shift.
  assign w_mplr_empty = (r_mplr[OP_W-1:1] == '0);
  assign w_acc_nxt    = r_mplr[0] ? w_sum : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mif.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if ((r_cnt == ITER_LAST) || ((EARLY_EXIT != 0) && w_mplr_empty)) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (mif.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_mcand <= {{(PROD_W-OP_W){1'b0}}, mif.a};
      r_mplr  <= mif.b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc_nxt;
      r_mcand <= {r_mcand[PROD_W-2:0], 1'b0};
      r_mplr  <= {1'b0, r_mplr[OP_W-1:1]};
      r_cnt   <= r_cnt + 3'd1;
      if (w_finish) begin
        r_p <= w_acc_nxt;
      end
    end
  end

  // An 8x8 product fits in 16 bits, so the adder never carries out.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == RUN)) begin
      assert (w_cout == 1'b0);
    end
  end

  assign mif.busy = (r_state == RUN);
  assign mif.done = (r_state == DONE);
  assign mif.p    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_mul8.sv
// ============================================================================
// Module   : tb_shift_add_mul8
// Purpose  : Directed and random self-checking bench, both EARLY_EXIT builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_mul8;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  shift_add_mul8_if if0 ();
  shift_add_mul8_if if1 ();

  shift_add_mul8 #(.EARLY_EXIT(0)) dut0 (.clk(clk), .rst(rst), .mif(if0));
  shift_add_mul8 #(.EARLY_EXIT(1)) dut1 (.clk(clk), .rst(rst), .mif(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && if0.busy) begin
      n_cmp++;
      if (dut0.w_cout !== 1'b0) begin
        n_fail++;
        $display("FAIL cout0: got %b want 0", dut0.w_cout);
      end
    end
  end

  task automatic drive(input bit ee, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (ee) begin
      if1.start = s; if1.a = a; if1.b = b;
    end else begin
      if0.start = s; if0.a = a; if0.b = b;
    end
  endtask

  task automatic sample(input bit ee, output logic busy, output logic done, output logic [15:0] p);
    if (ee) begin
      busy = if1.busy; done = if1.done; p = if1.p;
    end else begin
      busy = if0.busy; done = if0.done; p = if0.p;
    end
  endtask

  // Returns at the negedge of the DONE cycle; lat counts RUN cycles seen.
  task automatic run_op(input bit ee, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat, output bit tmo);
    logic bsy, dn;
    @(negedge clk);
    drive(ee, 1'b1, a, b);
    @(negedge clk);
    drive(ee, 1'b0, ~a, ~b);
    lat = 0;
    tmo = 1'b1;
    p   = '0;
    for (int i = 0; i < 20; i++) begin
      sample(ee, bsy, dn, p);
      if (dn) begin
        tmo = 1'b0;
        break;
      end
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic bsy, dn;
    logic [15:0] p;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    for (int e = 0; e < 2; e++) begin
      sample(e[0], bsy, dn, p);
      n_cmp++;
      if ({bsy, dn, p} !== 18'h0) begin
        n_fail++;
        $display("FAIL reset%0d: busy=%b done=%b p=%h want 0/0/0000", e, bsy, dn, p);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] p;
    int lat;
    bit tmo;
    logic bsy, dn;
    run_op(1'b0, 8'd13, 8'd11, p, lat, tmo);
    n_cmp++;
    if (tmo || p !== 16'd143 || lat != 8) begin
      n_fail++;
      $display("FAIL basic13x11: p=%0d lat=%0d tmo=%b want p=143 lat=8", p, lat, tmo);
    end
    repeat (3) @(negedge clk);
    sample(1'b0, bsy, dn, p);
    n_cmp++;
    if (dn !== 1'b0 || bsy !== 1'b0 || p !== 16'd143) begin
      n_fail++;
      $display("FAIL basic_hold: busy=%b done=%b p=%0d want 0/0/143", bsy, dn, p);
    end
  endtask

  task automatic test_max();
    logic [15:0] p;
    int lat;
    bit tmo;
    run_op(1'b0, 8'd255, 8'd255, p, lat, tmo);
    n_cmp++;
    if (tmo || p !== 16'hFE01 || lat != 8) begin
      n_fail++;
      $display("FAIL max255: p=%h lat=%0d tmo=%b want p=fe01 lat=8", p, lat, tmo);
    end
  endtask

  task automatic test_early_exit();
    logic [15:0] p;
    int lat;
    bit tmo;
    run_op(1'b1, 8'd200, 8'd0, p, lat, tmo);
    n_cmp++;
    if (tmo || p !== 16'd0 || lat != 1) begin
      n_fail++;
      $display("FAIL ee_b0: p=%0d lat=%0d tmo=%b want p=0 lat=1", p, lat, tmo);
    end
    run_op(1'b1, 8'd7, 8'd4, p, lat, tmo);
    n_cmp++;
    if (tmo || p !== 16'd28 || lat != 3) begin
      n_fail++;
      $display("FAIL ee_7x4: p=%0d lat=%0d tmo=%b want p=28 lat=3", p, lat, tmo);
    end
    run_op(1'b1, 8'd3, 8'd128, p, lat, tmo);
    n_cmp++;
    if (tmo || p !== 16'd384 || lat != 8) begin
      n_fail++;
      $display("FAIL ee_3x128: p=%0d lat=%0d tmo=%b want p=384 lat=8", p, lat, tmo);
    end
  endtask

  task automatic test_back_to_back();
    logic bsy, dn;
    logic [15:0] p;
    int lat;
    bit got;
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd5, 8'd6);
    @(negedge clk);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample(1'b0, bsy, dn, p);
      if (dn) begin
        got = 1'b1;
        break;
      end
      drive(1'b0, 1'b1, 8'($urandom), 8'($urandom));
      lat++;
      @(negedge clk);
    end
    n_cmp++;
    if (!got || p !== 16'd30 || lat != 8) begin
      n_fail++;
      $display("FAIL held_5x6: p=%0d lat=%0d got=%b want p=30 lat=8", p, lat, got);
    end
    drive(1'b0, 1'b1, 8'd10, 8'd3);
    @(negedge clk);
    sample(1'b0, bsy, dn, p);
    n_cmp++;
    if (bsy !== 1'b1 || dn !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b want 1/0", bsy, dn);
    end
    drive(1'b0, 1'b0, 8'hA5, 8'h5A);
    lat = 1;
    got = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      sample(1'b0, bsy, dn, p);
      if (dn) begin
        got = 1'b1;
        break;
      end
      lat++;
      @(negedge clk);
    end
    n_cmp++;
    if (!got || p !== 16'd30 || lat != 8) begin
      n_fail++;
      $display("FAIL b2b_10x3: p=%0d lat=%0d got=%b want p=30 lat=8", p, lat, got);
    end
  endtask

  task automatic test_reset_mid();
    logic bsy, dn;
    logic [15:0] p;
    int pulses;
    int lat;
    bit tmo;
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd9, 8'd9);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample(1'b0, bsy, dn, p);
    n_cmp++;
    if (bsy !== 1'b0 || dn !== 1'b0 || p !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b done=%b p=%0d want 0/0/0", bsy, dn, p);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if0.done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL rst_nodone: pulses=%0d want 0", pulses);
    end
    run_op(1'b0, 8'd9, 8'd9, p, lat, tmo);
    n_cmp++;
    if (tmo || p !== 16'd81 || lat != 8) begin
      n_fail++;
      $display("FAIL rst_rerun: p=%0d lat=%0d tmo=%b want p=81 lat=8", p, lat, tmo);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic [15:0] p;
    int lat, exp_lat;
    bit tmo;
    for (int e = 0; e < 2; e++) begin
      for (int k = 0; k < 1000; k++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        exp_lat = 8;
        if (e == 1) begin
          exp_lat = 1;
          for (int j = 0; j < 8; j++) if (b[j]) exp_lat = j + 1;
        end
        run_op(e[0], a, b, p, lat, tmo);
        n_cmp++;
        if (tmo || p !== 16'(a * b) || lat != exp_lat) begin
          n_fail++;
          $display("FAIL rand ee=%0d %0dx%0d: p=%0d lat=%0d want p=%0d lat=%0d",
                   e, a, b, p, lat, 16'(a * b), exp_lat);
        end
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_max();
    test_early_exit();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
